// File: rtl/rvlab_jtag_pkg.sv
// Shared types and constants for the RV lab JTAG scan engine and its users.
package rvlab_jtag_pkg;

  typedef enum logic [2:0] {
    ST_RESET_SEQ,
    ST_IDLE,
    ST_SELECT,
    ST_CAPTURE,
    ST_SHIFT_ENTER,
    ST_SHIFT,
    ST_UPDATE,
    ST_RETURN
  } jtag_scan_state_e;

  localparam int JTAG_DMI_LEN = 41;
  localparam int JTAG_IR_LEN  = 5;

  localparam logic [JTAG_IR_LEN-1:0] JTAG_IR_IDCODE = 5'h01;
  localparam logic [JTAG_IR_LEN-1:0] JTAG_IR_DTMCS  = 5'h10;
  localparam logic [JTAG_IR_LEN-1:0] JTAG_IR_DMI    = 5'h11;

  // TCK periods spent in Test-Logic-Reset before the final TMS=0 period.
  localparam int JTAG_TLR_PERIODS = 5;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: free-runs while enabled, restarting its phase one cycle after enable rises.
module jtag_tck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tck,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          en_d;
  logic          run;
  logic          wrap;

  // The delayed enable gives one alignment cycle before the first half-period.
  assign run      = en && en_d;
  assign wrap     = run && (cnt == CW'(CLK_DIV - 1));
  assign rise_stb = wrap && !tck;
  assign fall_stb = wrap && tck;

  // Half-period counter and TCK level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tck  <= 1'b0;
      en_d <= 1'b0;
    end else begin
      en_d <= en;
      if (!run) begin
        cnt <= '0;
        tck <= 1'b0;
      end else if (wrap) begin
        cnt <= '0;
        tck <= ~tck;
      end else begin
        cnt <= cnt + CW'(1'b1);
      end
    end
  end

endmodule

// File: rtl/jtag_scan_master.sv
// Word-level IR/DR scan requests in, IEEE 1149.1 TAP pin sequences out.
module jtag_scan_master
  import rvlab_jtag_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DR_MAX  = JTAG_DMI_LEN,
  parameter int LEN_W   = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_is_ir_i,
  input  logic [LEN_W-1:0]  req_len_i,
  input  logic [DR_MAX-1:0] req_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DR_MAX-1:0] rsp_data_o,
  output logic              jtag_tck_o,
  output logic              jtag_tms_o,
  output logic              jtag_tdi_o,
  output logic              jtag_trst_no,
  input  logic              jtag_tdo_i
);

  jtag_scan_state_e  state, next_state;
  logic              tck, rise_stb, fall_stb;
  logic              is_ir, sel_second, ret_end;
  logic [LEN_W-1:0]  len, cnt;
  logic [DR_MAX-1:0] data, cap;
  logic              tms, tdi, trst_n, rsp_valid;
  logic              accept, last_bit;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] raw);
    if (raw == '0) return LEN_W'(1'b1);
    else if (raw > LEN_W'(DR_MAX)) return LEN_W'(DR_MAX);
    else return raw;
  endfunction

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk      (clk_i),
    .rst      (rst_i),
    .en       (state != ST_IDLE),
    .tck      (tck),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  assign req_ready_o  = (state == ST_IDLE) && !rsp_valid;
  assign accept       = req_valid_i && req_ready_o;
  assign last_bit     = (cnt == len - LEN_W'(1'b1));
  assign rsp_valid_o  = rsp_valid;
  assign rsp_data_o   = cap;
  assign jtag_tck_o   = tck;
  assign jtag_tms_o   = tms;
  assign jtag_tdi_o   = tdi;
  assign jtag_trst_no = trst_n;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_RESET_SEQ;
    else       state <= next_state;
  end

  // Next state: every TAP period ends on a TCK falling edge.
  always_comb begin
    next_state = state;
    case (state)
      ST_RESET_SEQ:   if (fall_stb && cnt == LEN_W'(JTAG_TLR_PERIODS)) next_state = ST_IDLE;
                      else next_state = state;
      ST_IDLE:        if (accept) next_state = ST_SELECT;
                      else next_state = state;
      ST_SELECT:      if (fall_stb && (!is_ir || sel_second)) next_state = ST_CAPTURE;
                      else next_state = state;
      ST_CAPTURE:     if (fall_stb) next_state = ST_SHIFT_ENTER;
                      else next_state = state;
      ST_SHIFT_ENTER: if (fall_stb) next_state = ST_SHIFT;
                      else next_state = state;
      ST_SHIFT:       if (fall_stb && last_bit) next_state = ST_UPDATE;
                      else next_state = state;
      ST_UPDATE:      if (fall_stb) next_state = ST_RETURN;
                      else next_state = state;
      ST_RETURN:      if (ret_end) next_state = ST_IDLE;
                      else next_state = state;
      default:        next_state = ST_RESET_SEQ;
    endcase
  end

  // Pin drivers, request latch, capture register and response flag.
  // TMS/TDI are set on the falling edge that starts the period they belong to.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tms        <= 1'b1;
      tdi        <= 1'b0;
      trst_n     <= 1'b0;
      rsp_valid  <= 1'b0;
      cap        <= '0;
      data       <= '0;
      len        <= '0;
      cnt        <= '0;
      is_ir      <= 1'b0;
      sel_second <= 1'b0;
      ret_end    <= 1'b0;
    end else begin
      trst_n <= 1'b1;
      if (rsp_valid && rsp_ready_i) rsp_valid <= 1'b0;
      if (rise_stb && state == ST_SHIFT) cap[cnt] <= jtag_tdo_i;
      case (state)
        ST_RESET_SEQ: begin
          if (fall_stb) begin
            cnt <= cnt + LEN_W'(1'b1);
            if (cnt == LEN_W'(JTAG_TLR_PERIODS - 1)) tms <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (accept) begin
            is_ir      <= req_is_ir_i;
            len        <= clamp_len(req_len_i);
            data       <= req_data_i;
            cap        <= '0;
            cnt        <= '0;
            sel_second <= 1'b0;
            tms        <= 1'b1;
          end
        end
        ST_SELECT: begin
          if (fall_stb) begin
            if (is_ir && !sel_second) sel_second <= 1'b1;
            else tms <= 1'b0;
          end
        end
        ST_SHIFT_ENTER: begin
          if (fall_stb) begin
            tdi <= data[0];
            tms <= (len == LEN_W'(1'b1));
          end
        end
        ST_SHIFT: begin
          if (fall_stb) begin
            if (last_bit) begin
              tdi <= 1'b0;
              tms <= 1'b1;
            end else begin
              cnt <= cnt + LEN_W'(1'b1);
              tdi <= data[cnt + LEN_W'(1'b1)];
              tms <= (cnt + LEN_W'(2'd2) == len);
            end
          end
        end
        ST_UPDATE: begin
          if (fall_stb) tms <= 1'b0;
        end
        ST_RETURN: begin
          if (fall_stb) begin
            ret_end <= 1'b1;
          end else if (ret_end) begin
            ret_end   <= 1'b0;
            rsp_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_scan_master.sv
// Directed bench for jtag_scan_master against a behavioural 1149.1 TAP with a 32-bit IDCODE.
module tb_jtag_scan_master;
  import rvlab_jtag_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int DR_MAX  = 41;
  localparam int LEN_W   = 6;

  localparam int TLR = 0,  RTI = 1,  SELDR = 2,  CAPDR = 3,  SHDR = 4,  EX1DR = 5,  PAUDR = 6,  EX2DR = 7;
  localparam int UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12, PAUIR = 13, EX2IR = 14, UPIR = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0, req_is_ir = 1'b0, rsp_ready = 1'b0;
  logic [LEN_W-1:0]  req_len = '0;
  logic [DR_MAX-1:0] req_data = '0;
  logic              req_ready, rsp_valid, tck, tms, tdi, trst_n;
  logic [DR_MAX-1:0] rsp_data;
  logic              tdo = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  jtag_scan_master #(.CLK_DIV(CLK_DIV), .DR_MAX(DR_MAX), .LEN_W(LEN_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_is_ir_i  (req_is_ir),
    .req_len_i    (req_len),
    .req_data_i   (req_data),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .jtag_tck_o   (tck),
    .jtag_tms_o   (tms),
    .jtag_tdi_o   (tdi),
    .jtag_trst_no (trst_n),
    .jtag_tdo_i   (tdo)
  );

  always #5 clk = ~clk;

  // ---------------- TAP model ----------------
  int                     tap = TLR;
  logic [JTAG_IR_LEN-1:0] ir = JTAG_IR_IDCODE;
  logic [JTAG_IR_LEN-1:0] ir_sh = '0;
  logic [63:0]            dr = '0;
  int                     n_rise = 0, n_shift = 0;
  logic [63:0]            tms_log = '0, tdi_log = '0;

  function automatic int dr_len(input logic [JTAG_IR_LEN-1:0] op);
    case (op)
      JTAG_IR_IDCODE, JTAG_IR_DTMCS: return 32;
      JTAG_IR_DMI:                   return 41;
      default:                       return 1;
    endcase
  endfunction

  function automatic logic [63:0] dr_capture(input logic [JTAG_IR_LEN-1:0] op);
    case (op)
      JTAG_IR_IDCODE: return 64'h0000_0000_DEAD_BEEF;
      JTAG_IR_DTMCS:  return 64'h0000_0000_0000_5071;
      default:        return 64'h0;
    endcase
  endfunction

  function automatic int tap_next(input int s, input logic t);
    case (s)
      TLR:   return t ? TLR   : RTI;
      RTI:   return t ? SELDR : RTI;
      SELDR: return t ? SELIR : CAPDR;
      CAPDR: return t ? EX1DR : SHDR;
      SHDR:  return t ? EX1DR : SHDR;
      EX1DR: return t ? UPDR  : PAUDR;
      PAUDR: return t ? EX2DR : PAUDR;
      EX2DR: return t ? UPDR  : SHDR;
      UPDR:  return t ? SELDR : RTI;
      SELIR: return t ? TLR   : CAPIR;
      CAPIR: return t ? EX1IR : SHIR;
      SHIR:  return t ? EX1IR : SHIR;
      EX1IR: return t ? UPIR  : PAUIR;
      PAUIR: return t ? EX2IR : PAUIR;
      EX2IR: return t ? UPIR  : SHIR;
      UPIR:  return t ? SELDR : RTI;
      default: return TLR;
    endcase
  endfunction

  always @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tap <= TLR;
      ir  <= JTAG_IR_IDCODE;
    end else begin
      n_rise  <= n_rise + 1;
      tms_log <= {tms_log[62:0], tms};
      case (tap)
        TLR:   ir <= JTAG_IR_IDCODE;
        CAPDR: dr <= dr_capture(ir);
        SHDR: begin
          dr      <= (dr >> 1) | (64'(tdi) << (dr_len(ir) - 1));
          n_shift <= n_shift + 1;
          tdi_log <= {tdi, tdi_log[63:1]};
        end
        CAPIR: ir_sh <= 5'b00001;
        SHIR: begin
          ir_sh   <= {tdi, ir_sh[JTAG_IR_LEN-1:1]};
          n_shift <= n_shift + 1;
          tdi_log <= {tdi, tdi_log[63:1]};
        end
        UPIR:  ir <= ir_sh;
        default: ;
      endcase
      tap <= tap_next(tap, tms);
    end
  end

  always @(negedge tck) begin
    tdo <= (tap == SHDR) ? dr[0] : ((tap == SHIR) ? ir_sh[0] : 1'b0);
  end

  // ---------------- helpers ----------------
  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget);
    int c = 0;
    while (!req_ready && c < budget) begin
      tick();
      c++;
    end
  endtask

  // Edges from the accept edge until rsp_valid is seen.
  task automatic wait_rsp(output int lat);
    int c = 0;
    while (!rsp_valid && c < 2000) begin
      tick();
      c++;
    end
    lat = c;
  endtask

  task automatic run_scan(input logic is_ir, input logic [LEN_W-1:0] len,
                          input logic [DR_MAX-1:0] d, output int lat);
    req_valid = 1'b1;
    req_is_ir = is_ir;
    req_len   = len;
    req_data  = d;
    wait_ready(1000);
    tick();
    req_valid = 1'b0;
    wait_rsp(lat);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic check_reset_seq(input string tag, input int base_rise);
    check_eq({tag, "_ready"}, 64'(req_ready), 64'd1);
    check_eq({tag, "_trst"}, 64'(trst_n), 64'd1);
    check_eq({tag, "_periods"}, 64'(n_rise - base_rise), 64'd6);
    check_eq({tag, "_tms"}, 64'(tms_log[5:0]), 64'(6'b111110));
    check_eq({tag, "_tap_rti"}, 64'(tap), 64'(RTI));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, b_rise, b_shift, saw_valid;

    // Reset state
    repeat (3) tick();
    check_eq("rst_tck", 64'(tck), 64'd0);
    check_eq("rst_tms", 64'(tms), 64'd1);
    check_eq("rst_tdi", 64'(tdi), 64'd0);
    check_eq("rst_trst", 64'(trst_n), 64'd0);
    check_eq("rst_ready", 64'(req_ready), 64'd0);
    check_eq("rst_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_data", 64'(rsp_data), 64'd0);
    b_rise = n_rise;
    rst = 1'b0;
    tick();
    check_eq("trst_release", 64'(trst_n), 64'd1);
    wait_ready(200);
    check_reset_seq("rseq", b_rise);
    repeat (20) tick();
    check_eq("idle_no_tck", 64'(n_rise - b_rise), 64'd6);
    check_eq("idle_tck_low", 64'(tck), 64'd0);

    // IR scan selecting IDCODE
    b_rise = n_rise; b_shift = n_shift;
    run_scan(1'b1, 6'd5, 41'h01, lat);
    check_eq("ir_valid", 64'(rsp_valid), 64'd1);
    check_eq("ir_data", 64'(rsp_data), 64'h01);
    check_eq("ir_latency", 64'(lat), 64'd90);
    check_eq("ir_periods", 64'(n_rise - b_rise), 64'd11);
    check_eq("ir_tms", 64'(tms_log[10:0]), 64'(11'b110_0000_0110));
    check_eq("ir_nshift", 64'(n_shift - b_shift), 64'd5);
    check_eq("ir_tdi", 64'(tdi_log[63:59]), 64'(5'h01));
    check_eq("ir_model", 64'(ir), 64'(JTAG_IR_IDCODE));
    take_rsp();
    check_eq("ir_consumed", 64'(rsp_valid), 64'd0);

    // DR scan reading IDCODE
    b_rise = n_rise;
    run_scan(1'b0, 6'd32, 41'h0, lat);
    check_eq("idc_data", 64'(rsp_data), 64'hDEAD_BEEF);
    check_eq("idc_latency", 64'(lat), 64'd298);
    check_eq("idc_periods", 64'(n_rise - b_rise), 64'd37);
    check_eq("idc_tms", 64'(tms_log[36:0]), 64'({1'b1, 33'b0, 3'b110}));

    // Backpressure with a queued request
    req_valid = 1'b1; req_is_ir = 1'b0; req_len = 6'd32; req_data = 41'h0;
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_valid", 64'(rsp_valid), 64'd1);
      check_eq("bp_data", 64'(rsp_data), 64'hDEAD_BEEF);
      check_eq("bp_ready", 64'(req_ready), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("bp_consumed", 64'(rsp_valid), 64'd0);
    check_eq("bp_ready_after", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    check_eq("bp_accepted", 64'(req_ready), 64'd0);
    wait_rsp(lat);
    check_eq("bp2_latency", 64'(lat), 64'd298);
    check_eq("bp2_data", 64'(rsp_data), 64'hDEAD_BEEF);
    take_rsp();

    // Length clamp: 0 -> one bit
    b_rise = n_rise; b_shift = n_shift;
    run_scan(1'b0, 6'd0, 41'h1FF_FFFF_FFFF, lat);
    check_eq("len0_data", 64'(rsp_data), 64'h1);
    check_eq("len0_nshift", 64'(n_shift - b_shift), 64'd1);
    check_eq("len0_periods", 64'(n_rise - b_rise), 64'd6);
    check_eq("len0_latency", 64'(lat), 64'd50);
    take_rsp();

    // Length clamp: 63 -> 41 bits, TDI wraps through the 32-bit IDCODE register
    b_rise = n_rise; b_shift = n_shift;
    run_scan(1'b0, 6'd63, 41'h000_0000_01A5, lat);
    check_eq("len63_data", 64'(rsp_data), 64'h1A5_DEAD_BEEF);
    check_eq("len63_nshift", 64'(n_shift - b_shift), 64'd41);
    check_eq("len63_periods", 64'(n_rise - b_rise), 64'd46);
    check_eq("len63_latency", 64'(lat), 64'd370);
    take_rsp();

    // Select DMI, then reset in the middle of a 41-bit DMI scan
    run_scan(1'b1, 6'd5, 41'h11, lat);
    check_eq("dmi_ir_data", 64'(rsp_data), 64'h01);
    check_eq("dmi_ir_model", 64'(ir), 64'(JTAG_IR_DMI));
    take_rsp();
    req_valid = 1'b1; req_is_ir = 1'b0; req_len = 6'd41; req_data = 41'h155_5555_5555;
    wait_ready(100);
    tick();
    req_valid = 1'b0;
    b_shift = n_shift;
    begin
      int c = 0;
      while (n_shift - b_shift < 10 && c < 2000) begin
        tick();
        c++;
      end
    end
    check_eq("mid_reached_bit10", 64'(n_shift - b_shift), 64'd10);
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    check_eq("mid_tck", 64'(tck), 64'd0);
    check_eq("mid_tms", 64'(tms), 64'd1);
    check_eq("mid_tdi", 64'(tdi), 64'd0);
    check_eq("mid_trst", 64'(trst_n), 64'd0);
    check_eq("mid_ready", 64'(req_ready), 64'd0);
    check_eq("mid_valid", 64'(rsp_valid), 64'd0);
    check_eq("mid_data", 64'(rsp_data), 64'd0);
    check_eq("mid_tap_tlr", 64'(tap), 64'(TLR));
    repeat (3) tick();
    b_rise = n_rise;
    rst = 1'b0;
    saw_valid = 0;
    begin
      int c = 0;
      while (!req_ready && c < 200) begin
        if (rsp_valid) saw_valid = 1;
        tick();
        c++;
      end
    end
    check_eq("mid_no_rsp", 64'(saw_valid), 64'd0);
    check_reset_seq("mid_rseq", b_rise);
    check_eq("mid_ir_idcode", 64'(ir), 64'(JTAG_IR_IDCODE));

    // Engine usable again after the replayed reset sequence
    run_scan(1'b0, 6'd32, 41'h0, lat);
    check_eq("post_data", 64'(rsp_data), 64'hDEAD_BEEF);
    check_eq("post_latency", 64'(lat), 64'd298);
    take_rsp();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jtag_scan_master.md
# jtag_scan_master

Synthesizable JTAG scan engine that drives the board-level JTAG pins (`tck`/`tms`/`tdi`/`trst_n`, `tdo` return) of the RV lab system. It turns word-level IR/DR scan requests into IEEE 1149.1 TAP pin sequences. It is the hardware counterpart of the behavioural JTAG master, so on-chip or FPGA-side agents can reach the debug module (DMI, DTMCS, IDCODE) without a bench.

## Interface
- `CLK_DIV`, default 4: `clk_i` cycles per TCK half-period; must be ≥2.
- `DR_MAX`, default 41: maximum scan length in bits (DMI = 7 addr + 32 data + 2 op).
- `LEN_W`, default 6: width of the length field; must satisfy 2^LEN_W > DR_MAX.
- `clk_i`  in  1  system clock; the only clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_valid_i`  in  1  scan request valid.
- `req_ready_o`  out  1  engine idle in Run-Test/Idle and no response pending.
- `req_is_ir_i`  in  1  1 = IR scan, 0 = DR scan.
- `req_len_i`  in  LEN_W  number of bits to shift.
- `req_data_i`  in  DR_MAX  TDI data, LSB shifted first.
- `rsp_valid_o`  out  1  captured TDO data valid.
- `rsp_ready_i`  in  1  consumer accepts the response.
- `rsp_data_o`  out  DR_MAX  captured TDO, right-aligned; bits ≥ len are zero.
- `jtag_tck_o`  out  1  TCK.
- `jtag_tms_o`  out  1  TMS.
- `jtag_tdi_o`  out  1  TDI.
- `jtag_trst_no`  out  1  TAP reset, active-low.
- `jtag_tdo_i`  in  1  TDO; the target must be synchronous to `clk_i`.

## Operation
- Reset values:
  - `jtag_tck_o`=0, `jtag_tms_o`=1, `jtag_tdi_o`=0, `jtag_trst_no`=0.
  - `req_ready_o`=0, `rsp_valid_o`=0, `rsp_data_o`=0.
- Pin update rules:
  - TMS and TDI change only on TCK falling edges, and on the first half-period after reset.
  - TDO is sampled on TCK rising edges.
- FSM states:
  - RESET_SEQ:
    - `jtag_trst_no` goes to 1 on the first clock after reset release.
    - Then 5 TCK periods with TMS=1 (Test-Logic-Reset), then 1 period with TMS=0, landing in Run-Test/Idle.
    - Then go to IDLE.
  - IDLE:
    - TCK is held low.
    - `req_ready_o` = (state==IDLE) && !`rsp_valid_o`.
    - On `req_valid_i` && `req_ready_o`: latch is_ir, the clamped length L, and the data. Go to SELECT.
  - SELECT: TMS=1 for one period (Select-DR). For IR, one more period with TMS=1 (Select-IR).
  - CAPTURE: TMS=0 for one period.
  - SHIFT_ENTER: TMS=0 for one period, entering Shift-xR.
  - SHIFT:
    - L periods; bit i is driven on TDI.
    - TMS=0, except TMS=1 on bit L-1 (enters Exit1).
    - TDO sampled on each rising edge goes into bit i of the capture register.
  - UPDATE: TMS=1 for one period.
  - RETURN: TMS=0 for one period (Run-Test/Idle). Then set `rsp_valid_o` and go to IDLE.
- Length clamp: L = max(1, min(`req_len_i`, DR_MAX)).
- Response handshake:
  - `rsp_valid_o` and `rsp_data_o` are held stable until `rsp_ready_i`.
  - The capture register is cleared when a request is accepted.
- Reset mid-scan: all outputs return asynchronously to their reset values. The pending request and response are dropped, and RESET_SEQ replays.
- Simultaneous `rsp_ready_i` and `req_valid_i` in the same cycle: the response is consumed; the request is accepted in the next cycle at the earliest (`req_ready_o` is low in that cycle).

## Timing
- TCK period is 2·`CLK_DIV` clk cycles, 50 % duty cycle.
- A divider strobe marks each rise and fall.
- Scan duration in TCK periods:
  - DR: L+5.
  - IR: L+6.
- `rsp_valid_o` rises 1 clk after the falling edge that ends the RETURN period.
- Request-to-`rsp_valid_o` latency (DR) = (L+5)·2·`CLK_DIV` + 2 clk cycles. This includes 1 accept cycle and 1 cycle for the first TCK half-period alignment.
- Back-to-back throughput is limited only by the response handshake. There are no extra idle TCK periods.

## Structure
- `rvlab_jtag_pkg` holds:
  - the FSM state enum `jtag_scan_state_e`;
  - the constant `JTAG_DMI_LEN` = 41;
  - `JTAG_IR_LEN` = 5;
  - the IR opcodes (IDCODE = 5'h01, DTMCS = 5'h10, DMI = 5'h11).
- Sub-module `jtag_tck_gen`:
  - Divider counter producing `tck`, `rise_stb` and `fall_stb`.
  - Enabled only outside IDLE.
  - Restarts phase on enable.

## Test plan
- Reset sequence: hold `rst_i` for 3 cycles, then release.
  - `jtag_trst_no`=0 during reset and 1 after.
  - 5 TCK periods with TMS=1, then 1 with TMS=0.
  - Then `req_ready_o`=1 and TCK stays idle low.
- IR scan: is_ir=1, len 5, data 5'h01, against the bench TAP model.
  - TMS sequence 1,1,0,0,0,0,0,0,1,1,0.
  - TDI bits 1,0,0,0,0.
  - `rsp_data_o`=5'h01 (IR capture pattern).
- DR scan: len 32 after IDCODE is selected; model IDCODE 32'hDEADBEEF.
  - `rsp_data_o`=32'hDEADBEEF.
  - `rsp_valid_o` exactly 37·8+2 clk cycles after accept (`CLK_DIV`=4).
- Backpressure: `rsp_ready_i` low for 10 cycles.
  - `rsp_valid_o` and data held stable; `req_ready_o`=0.
  - A queued request is accepted the cycle after the response handshake.
- Reset mid-scan: assert `rst_i` during shift bit 10 of a 41-bit DMI scan.
  - Outputs take reset values the same cycle.
  - No `rsp_valid_o`.
  - RESET_SEQ repeats.
- Length clamp:
  - len 0 → exactly 1 bit shifted, `rsp_data_o`[40:1]=0.
  - len 63 → 41 bits shifted, total 46 TCK periods.
